move_scheduler: RTL

Sequences player commands from the keyboard decoder into the 2048 board engine. Decoded key codes arrive as single-cycle strobes and are buffered in a small FIFO. Direction moves are issued to the board engine one at a time over a valid/ready handshake, and each move must complete before the next is issued. The reset key flushes pending work and drives a timed game-reset pulse.

---
 rtl/wildwest_pkg.sv | 27 ++
 rtl/move_fifo.sv | 58 +++++
 rtl/move_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/wildwest_pkg.sv
// Shared definitions for the move scheduler: key codes, direction type, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wildwest_pkg;

    localparam logic [3:0] KEY_LEFT  = 4'd0;
    localparam logic [3:0] KEY_RIGHT = 4'd1;
    localparam logic [3:0] KEY_UP    = 4'd2;
    localparam logic [3:0] KEY_DOWN  = 4'd3;
    localparam logic [3:0] KEY_RESET = 4'd8;
    localparam logic [3:0] KEY_NONE  = 4'd15;

    typedef logic [1:0] dir_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_CLEAR     = 2'd3
    } sched_state_e;

    // Direction keys occupy codes 0..3, so the upper two bits are zero.
    function automatic logic is_dir_key(input logic [3:0] code);
        return (code[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Small synchronous FIFO holding pending direction moves.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is refused when full unless a pop happens in the same cycle; flush wins over both.
module move_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FULL_CNT) || do_pop);

    // Pointer and occupancy bookkeeping; flush discards everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: occupancy gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/move_scheduler.sv
// Queues decoded keys and issues 2048 moves one at a time; reset key drives a timed game_rst pulse.
// Latency: key strobe in cycle n -> move_valid in n+2 when idle; reset key -> game_rst in n+1..n+RST_CYCLES.
// Backpressure: move_valid holds until move_ready; next move waits for move_done; full FIFO drops keys (sticky overflow).
module move_scheduler
    import wildwest_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RST_CYCLES = 4
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESET,
    input  logic [3:0]  key_code,
    input  logic        key_valid,
    input  logic        game_over,
    output logic [1:0]  move_dir,
    output logic        move_valid,
    input  logic        move_ready,
    input  logic        move_done,
    output logic        game_rst,
    output logic        busy,
    output logic [15:0] move_count,
    output logic        overflow
);
    localparam int CW = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0] CLR_LOAD = CW'(RST_CYCLES - 1);

    sched_state_e state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic [15:0]   move_count_q, move_count_d;
    logic          overflow_q, overflow_d;
    dir_t          move_dir_q;

    logic key_reset, key_dir;
    logic fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty, drop;
    dir_t fifo_rd_dat;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign key_reset = key_valid && (key_code == KEY_RESET);
    assign key_dir   = key_valid && is_dir_key(key_code);

    // Keys are only queued while a game is live and no reset is in progress.
    assign fifo_push  = key_dir && (state_q != S_CLEAR) && !game_over;
    assign fifo_pop   = (state_q == S_IDLE) && !fifo_empty && !game_over && !key_reset;
    // Holding flush while game_over is high empties anything queued when it rose.
    assign fifo_flush = key_reset || game_over;
    assign drop       = fifo_push && fifo_full && !fifo_pop;

    move_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk      (CLK100MHZ),
        .rst      (CPU_RESET),
        .push     (fifo_push),
        .push_dat (key_code[1:0]),
        .pop      (fifo_pop),
        .pop_dat  (fifo_rd_dat),
        .flush    (fifo_flush),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Next state, CLEAR countdown, move counter and overflow flag; reset key overrides all.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        move_count_d = move_count_q;
        overflow_d   = overflow_q;
        case (state_q)
            S_IDLE:      if (fifo_pop) state_d = S_ISSUE;
            S_ISSUE:     if (move_ready) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (move_done) begin
                             state_d = S_IDLE;
                             if (move_count_q != 16'hFFFF) move_count_d = move_count_q + 16'd1;
                         end
            S_CLEAR:     if (clr_cnt_q == '0) state_d = S_IDLE;
                         else clr_cnt_d = clr_cnt_q - CW'(1);
            default:     state_d = S_IDLE;
        endcase
        if (drop) overflow_d = 1'b1;
        if (key_reset) begin
            state_d      = S_CLEAR;
            clr_cnt_d    = CLR_LOAD;
            move_count_d = '0;
            overflow_d   = 1'b0;
        end
    end

    // State registers; move_dir captures the head entry as it is popped.
    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= '0;
            move_count_q <= '0;
            overflow_q   <= 1'b0;
            move_dir_q   <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            move_count_q <= move_count_d;
            overflow_q   <= overflow_d;
            if (fifo_pop) move_dir_q <= fifo_rd_dat;
        end
    end

    assign move_valid = (state_q == S_ISSUE);
    assign game_rst   = (state_q == S_CLEAR);
    assign busy       = (state_q != S_IDLE) || (fifo_count != '0);
    assign move_dir   = move_dir_q;
    assign move_count = move_count_q;
    assign overflow   = overflow_q;

endmodule
